// File: rtl/rr_mux_sel_4.sv
// rtl/rr_mux_sel_4.sv - four-channel buffered round-robin scheduler driving a 4:1 mux select
module rr_mux_sel_4 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   in_valid,
    input  logic [W-1:0] in_data0,
    input  logic [W-1:0] in_data1,
    input  logic [W-1:0] in_data2,
    input  logic [W-1:0] in_data3,
    output logic [3:0]   in_ready,
    output logic [W-1:0] d0,
    output logic [W-1:0] d1,
    output logic [W-1:0] d2,
    output logic [W-1:0] d3,
    output logic [1:0]   sel,
    output logic         out_valid,
    input  logic         out_ack
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t       r_state, w_state_nxt;
    logic [3:0]   r_full, w_full_nxt, w_wr, w_cand;
    logic [W-1:0] r_d [4];
    logic [W-1:0] w_wdata [4];
    logic [1:0]   r_sel, w_sel_nxt, r_ptr, w_ptr_nxt;
    logic [1:0]   w_start, w_gnt, w_idx;
    logic         r_out_valid, w_out_valid_nxt, w_found;

    assign w_wdata[0] = in_data0;
    assign w_wdata[1] = in_data1;
    assign w_wdata[2] = in_data2;
    assign w_wdata[3] = in_data3;

    assign w_wr      = in_valid & ~r_full;
    assign in_ready  = ~r_full;
    assign d0        = r_d[0];
    assign d1        = r_d[1];
    assign d2        = r_d[2];
    assign d3        = r_d[3];
    assign sel       = r_sel;
    assign out_valid = r_out_valid;

    // In HOLD the channel being released is excluded and the search resumes after it.
    always_comb begin
        if (r_state == IDLE) begin
            w_cand  = r_full;
            w_start = r_ptr;
        end else begin
            w_cand  = r_full & ~(4'b0001 << r_sel);
            w_start = r_sel + 2'd1;
        end
    end

    // Descending scan so the smallest offset from w_start wins.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = w_start;
        w_idx   = w_start;
        for (int k = 3; k >= 0; k--) begin
            w_idx = w_start + 2'(k);
            if (w_cand[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_sel_nxt       = r_sel;
        w_ptr_nxt       = r_ptr;
        w_out_valid_nxt = r_out_valid;
        w_full_nxt      = r_full | w_wr;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_sel_nxt       = w_gnt;
                    w_ptr_nxt       = w_gnt + 2'd1;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = HOLD;
                end
            end
            HOLD: begin
                if (out_ack) begin
                    w_full_nxt[r_sel] = 1'b0;
                    w_ptr_nxt         = r_sel + 2'd1;
                    if (w_found) begin
                        w_sel_nxt = w_gnt;
                        w_ptr_nxt = w_gnt + 2'd1;
                    end else begin
                        w_out_valid_nxt = 1'b0;
                        w_state_nxt     = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_full      <= 4'b0000;
            r_sel       <= 2'd0;
            r_ptr       <= 2'd0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_d[i] <= '0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_full      <= w_full_nxt;
            r_sel       <= w_sel_nxt;
            r_ptr       <= w_ptr_nxt;
            r_out_valid <= w_out_valid_nxt;
            for (int i = 0; i < 4; i++) begin
                if (w_wr[i]) begin
                    r_d[i] <= w_wdata[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_sel_4.sv
// tb/tb_rr_mux_sel_4.sv - self-checking bench for rr_mux_sel_4
module tb_rr_mux_sel_4;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   in_valid = 4'b0000;
    logic [W-1:0] in_data0 = '0;
    logic [W-1:0] in_data1 = '0;
    logic [W-1:0] in_data2 = '0;
    logic [W-1:0] in_data3 = '0;
    logic         out_ack = 1'b0;
    logic [3:0]   in_ready;
    logic [W-1:0] d0, d1, d2, d3;
    logic [1:0]   sel;
    logic         out_valid;

    always #5 clk = ~clk;

    rr_mux_sel_4 #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data0 (in_data0),
        .in_data1 (in_data1),
        .in_data2 (in_data2),
        .in_data3 (in_data3),
        .in_ready (in_ready),
        .d0       (d0),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .sel      (sel),
        .out_valid(out_valid),
        .out_ack  (out_ack)
    );

    typedef struct {
        logic [3:0]  vld;
        logic [15:0] data;
        logic        ack;
        logic [3:0]  rdy;
        logic        ov;
        logic [1:0]  sel;
        logic [3:0]  dsel;
    } vec_t;

    typedef struct {
        logic [1:0] ch;
        logic [3:0] data;
    } exp_t;

    vec_t tbl [13];
    exp_t sbq [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic [3:0] vld, input logic [15:0] data, input logic ack,
                                input logic [3:0] rdy, input logic ov, input logic [1:0] s,
                                input logic [3:0] ds);
        vec_t v;
        v.vld = vld; v.data = data; v.ack = ack;
        v.rdy = rdy; v.ov = ov; v.sel = s; v.dsel = ds;
        return v;
    endfunction

    function automatic logic [3:0] dsel_of(input logic [1:0] s);
        case (s)
            2'd0:    return d0;
            2'd1:    return d1;
            2'd2:    return d2;
            default: return d3;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] vld, input logic [15:0] data, input logic ack);
        exp_t e;
        in_valid = vld;
        in_data0 = data[3:0];
        in_data1 = data[7:4];
        in_data2 = data[11:8];
        in_data3 = data[15:12];
        out_ack  = ack;
        for (int i = 0; i < 4; i++) begin
            if (vld[i]) begin
                e.ch   = 2'(i);
                e.data = data[4*i +: 4];
                sbq.push_back(e);
            end
        end
    endtask

    task automatic consume();
        int idx;
        idx = -1;
        for (int j = 0; j < sbq.size(); j++) begin
            if (idx < 0 && sbq[j].ch == sel) idx = j;
        end
        if (idx < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got word on sel %0d, expected no pending word", sel);
        end else begin
            chk("sb_data", 16'(dsel_of(sel)), 16'(sbq[idx].data));
            sbq.delete(idx);
        end
    endtask

    // Any word acknowledged in the coming edge is retired from the scoreboard first.
    task automatic step();
        if (!rst && out_valid && out_ack) consume();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string nm, input logic [3:0] rdy, input logic ov,
                             input logic [1:0] s, input logic [3:0] ds);
        chk({nm, "_ready"}, 16'(in_ready), 16'(rdy));
        chk({nm, "_valid"}, 16'(out_valid), 16'(ov));
        if (ov) begin
            chk({nm, "_sel"}, 16'(sel), 16'(s));
            chk({nm, "_dsel"}, 16'(dsel_of(s)), 16'(ds));
        end
    endtask

    initial begin
        tbl[0]  = mk(4'b1111, 16'hdcba, 1'b0, 4'b0000, 1'b0, 2'd0, 4'h0);
        tbl[1]  = mk(4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b1, 2'd0, 4'ha);
        tbl[2]  = mk(4'b0000, 16'h0000, 1'b1, 4'b0001, 1'b1, 2'd1, 4'hb);
        tbl[3]  = mk(4'b0000, 16'h0000, 1'b1, 4'b0011, 1'b1, 2'd2, 4'hc);
        tbl[4]  = mk(4'b0000, 16'h0000, 1'b1, 4'b0111, 1'b1, 2'd3, 4'hd);
        tbl[5]  = mk(4'b0000, 16'h0000, 1'b1, 4'b1111, 1'b0, 2'd0, 4'h0);
        tbl[6]  = mk(4'b0100, 16'h0c00, 1'b0, 4'b1011, 1'b0, 2'd0, 4'h0);
        tbl[7]  = mk(4'b0000, 16'h0000, 1'b0, 4'b1011, 1'b1, 2'd2, 4'hc);
        tbl[8]  = mk(4'b0000, 16'h0000, 1'b1, 4'b1111, 1'b0, 2'd0, 4'h0);
        tbl[9]  = mk(4'b1001, 16'h8007, 1'b0, 4'b0110, 1'b0, 2'd0, 4'h0);
        tbl[10] = mk(4'b0000, 16'h0000, 1'b0, 4'b0110, 1'b1, 2'd3, 4'h8);
        tbl[11] = mk(4'b0000, 16'h0000, 1'b1, 4'b1110, 1'b1, 2'd0, 4'h7);
        tbl[12] = mk(4'b0000, 16'h0000, 1'b1, 4'b1111, 1'b0, 2'd0, 4'h0);

        #2 rst = 1'b1;
        #1;
        check_out("reset", 4'b1111, 1'b0, 2'd0, 4'h0);
        chk("reset_sel", 16'(sel), 16'd0);
        chk("reset_d", {d3, d2, d1, d0}, 16'h0000);
        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].vld, tbl[i].data, tbl[i].ack);
            step();
            check_out($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].ov, tbl[i].sel, tbl[i].dsel);
        end

        // Backpressure on channel 1; channel 3 arrives during the hold.
        drive(4'b0010, 16'h0090, 1'b0);
        step();
        check_out("bp_accept", 4'b1101, 1'b0, 2'd0, 4'h0);
        drive(4'b0000, 16'h0000, 1'b0);
        step();
        check_out("bp_grant", 4'b1101, 1'b1, 2'd1, 4'h9);
        for (int c = 0; c < 5; c++) begin
            drive((c == 1) ? 4'b1000 : 4'b0000, 16'he000, 1'b0);
            step();
            chk($sformatf("bp_hold%0d_sel", c), 16'(sel), 16'd1);
            chk($sformatf("bp_hold%0d_valid", c), 16'(out_valid), 16'd1);
            chk($sformatf("bp_hold%0d_d1", c), 16'(d1), 16'h9);
            chk($sformatf("bp_hold%0d_rdy1", c), 16'(in_ready[1]), 16'd0);
        end
        drive(4'b0000, 16'h0000, 1'b1);
        step();
        check_out("bp_next", 4'b0111, 1'b1, 2'd3, 4'he);
        drive(4'b0000, 16'h0000, 1'b1);
        step();
        check_out("bp_done", 4'b1111, 1'b0, 2'd0, 4'h0);

        // Late arrival: write lands with the ack, so one idle cycle precedes its grant.
        drive(4'b0001, 16'h0003, 1'b0);
        step();
        drive(4'b0000, 16'h0000, 1'b0);
        step();
        check_out("late_grant0", 4'b1110, 1'b1, 2'd0, 4'h3);
        drive(4'b0010, 16'h0060, 1'b1);
        step();
        check_out("late_idle", 4'b1101, 1'b0, 2'd0, 4'h0);
        drive(4'b0000, 16'h0000, 1'b0);
        step();
        check_out("late_grant1", 4'b1101, 1'b1, 2'd1, 4'h6);
        drive(4'b0000, 16'h0000, 1'b1);
        step();
        check_out("late_done", 4'b1111, 1'b0, 2'd0, 4'h0);

        // Asynchronous reset while three words are pending.
        drive(4'b0111, 16'h0321, 1'b0);
        step();
        drive(4'b0000, 16'h0000, 1'b0);
        step();
        check_out("mid_grant", 4'b1000, 1'b1, 2'd2, 4'h3);
        #2 rst = 1'b1;
        #1;
        check_out("mid_reset", 4'b1111, 1'b0, 2'd0, 4'h0);
        chk("mid_reset_sel", 16'(sel), 16'd0);
        chk("mid_reset_d", {d3, d2, d1, d0}, 16'h0000);
        sbq.delete();
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(4'b0000, 16'h0000, 1'b1);
            step();
            check_out($sformatf("post_rst%0d", c), 4'b1111, 1'b0, 2'd0, 4'h0);
        end
        drive(4'b0001, 16'h000f, 1'b0);
        step();
        drive(4'b0000, 16'h0000, 1'b0);
        step();
        check_out("post_rst_grant", 4'b1110, 1'b1, 2'd0, 4'hf);
        drive(4'b0000, 16'h0000, 1'b1);
        step();
        check_out("post_rst_done", 4'b1111, 1'b0, 2'd0, 4'h0);
        drive(4'b0000, 16'h0000, 1'b0);
        chk("sb_empty", 16'(sbq.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_mux_sel_4.md
# rr_mux_sel_4

Four-channel buffered round-robin scheduler that sits directly upstream of the 4:1 data multiplexer. It captures one word per input channel into a holding register and presents the four registers as the mux data inputs. It drives the mux select from a round-robin arbiter and holds that select stable until the downstream consumer acknowledges the muxed word. It turns four independent valid/ready producers into one fair, ordered stream through the combinational mux.

## Interface
- W, default 4, data width per channel; matches the mux data width.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  4  per-channel write request; bit i belongs to channel i.
- in_data0, in_data1, in_data2, in_data3  input  W each  per-channel write data.
- in_ready  output  4  per-channel accept; bit i = buffer i empty.
- d0, d1, d2, d3  output  W each  holding registers; connect to the mux data inputs.
- sel  output  2  registered select; connect to the mux select.
- out_valid  output  1  mux output word (d[sel]) is valid.
- out_ack  input  1  consumer took the current word; ignored when out_valid=0.

## Operation
- Per channel i: flag full[i] and register d_i.
  - Write when in_valid[i] & in_ready[i]: d_i <= in_data_i, full[i] <= 1.
  - in_ready[i] = ~full[i], combinational from the flag. A buffer is never refilled in the cycle it is released.
- Round-robin pointer ptr (2 bits).
  - Search order is ptr, ptr+1, ptr+2, ptr+3, modulo 4.
  - After granting channel g, ptr <= g+1 mod 4; granting 3 sets ptr to 0.
- Arbiter FSM, states IDLE and HOLD:
  - IDLE: if any full flag (value before this edge) is set, sel <= first full channel in search order, out_valid <= 1, go to HOLD. Otherwise stay in IDLE.
  - HOLD, out_ack=0: sel, out_valid and d_sel are unchanged; no other state changes except writes into other empty buffers.
  - HOLD, out_ack=1: full[sel] <= 0 and ptr <= sel+1.
    - If any other channel was full before this edge, grant the first one in search order (starting from sel+1) in the same edge and stay in HOLD. out_valid stays 1.
    - Otherwise out_valid <= 0 and go to IDLE.
  - Buffers written on the same edge are not candidates until the next edge.
- d_sel is frozen while out_valid=1, because its buffer is full and cannot be written. The mux output is therefore stable for the whole hold.
- Values of d_i for empty channels are don't-care to the consumer but are retained (not cleared).

## Timing
- Reset, asynchronous, effective immediately on rst=1 without waiting for an edge:
  - full = 0000, in_ready = 1111
  - d0..d3 = 0, sel = 0, ptr = 0
  - out_valid = 0, FSM = IDLE
- Latency: a word accepted at edge N has full set after N. If the FSM is idle, out_valid=1 with that sel after edge N+1.
- Throughput:
  - With out_ack held high and other channels pending: one word per cycle, no bubble between grants.
  - A single channel alone: at most one word every 3 cycles (accept, grant, ack/release).
- Simultaneous events:
  - out_ack with new writes in the same cycle: both take effect; new words are not eligible until the next edge.
  - All four in_valid in the same cycle: all accepted.
- Reset mid-HOLD: all state is dropped. Pending words are lost; no word is emitted after reset deasserts without a new write.

## Test plan
- Single word: reset, then in_valid=0100 with in_data2='hc for one cycle. After that edge in_ready=1011. One edge later out_valid=1, sel=2, d2='hc. Pulse out_ack: next edge out_valid=0, in_ready=1111.
- Full load back-to-back: write 'ha,'hb,'hc,'hd to channels 0..3 in one cycle, then hold out_ack=1. Required: sel goes 0,1,2,3 on consecutive cycles with out_valid continuously 1 and d[sel] equal to 'ha,'hb,'hc,'hd in order. out_valid drops after the 4th ack.
- Fairness wrap: grant channel 2 and ack it (ptr=3), then fill channels 0 and 3 together. Required grant order: 3 then 0.
- Backpressure: with sel=1 and out_ack=0 for 5 cycles, sel, out_valid and d1 stay constant and in_ready[1]=0. Writes to channel 3 during the hold are accepted and granted next, after the ack.
- Late arrival: in HOLD on channel 0 with no others full, assert out_ack and in_valid[1] in the same cycle. Required: next cycle out_valid=0 (IDLE), then the following cycle out_valid=1 with sel=1.
- Reset mid-operation: with three buffers full and out_valid=1, assert rst between clock edges. Outputs read zero and in_ready=1111 before the next edge. After release, out_valid stays 0 until a new write.
